// File: rtl/dl_region_loader.sv
// Download router from hps_io's ioctl port to a req/ack memory write port.
// Each ioctl index maps to its own region; writes pass through a 2-entry FIFO.
module dl_region_loader #(
    parameter int NUM_REGIONS  = 4,
    parameter int IN_AW        = 14,
    parameter int OUT_AW       = 25,
    parameter int REGION_SHIFT = 16,
    parameter int ROM_INDEX    = 0,
    parameter int RESET_HOLD   = 16,
    localparam int RW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [IN_AW-1:0]  ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic [OUT_AW-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_wr,
    input  logic              mem_ack,
    output logic              cpu_reset,
    output logic              load_done,
    output logic [IN_AW:0]    load_len,
    output logic [RW-1:0]     load_region,
    output logic              load_err
);
    localparam int              HW        = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(RESET_HOLD - 1);
    localparam logic [IN_AW:0]  LEN_MAX   = {1'b1, {IN_AW{1'b0}}};
    localparam logic [8:0]      NUM_IDX   = 9'(NUM_REGIONS);
    localparam logic [7:0]      ROM_IDX   = 8'(ROM_INDEX);
    localparam int              EW        = OUT_AW + 8;

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, HOLD} state_t;

    state_t          state;
    logic            dl_q, valid_r, pending_start;
    logic [7:0]      idx_r, pend_idx, start_idx;
    logic [HW-1:0]   hold_cnt;
    logic [EW-1:0]   ent0, ent1, push_word;
    logic [1:0]      count, count_nx;
    logic            rise, pop, push, wr_attempt, addr_ok, start, finish, to_drain;

    // Offsets that would spill into the next region are rejected.
    generate
        if (IN_AW > REGION_SHIFT) begin : g_addr_chk
            assign addr_ok = ~|ioctl_addr[IN_AW-1:REGION_SHIFT];
        end else begin : g_addr_fits
            assign addr_ok = 1'b1;
        end
    endgenerate

    always_comb begin
        rise       = ioctl_download & ~dl_q;
        pop        = (count != 2'd0) & mem_ack;
        wr_attempt = (state == ACTIVE) & ioctl_wr;
        // A full FIFO still takes a byte when the head leaves in the same cycle.
        push       = wr_attempt & valid_r & addr_ok & ((count != 2'd2) | pop);
        push_word  = {(OUT_AW'(idx_r[RW-1:0]) << REGION_SHIFT) | OUT_AW'(ioctl_addr), ioctl_dout};
        count_nx   = count;
        if (push & ~pop)
            count_nx = count + 2'd1;
        else if (pop & ~push)
            count_nx = count - 2'd1;
        start      = ((state == IDLE) | (state == HOLD)) & (rise | pending_start);
        start_idx  = pending_start ? pend_idx : ioctl_index;
        finish     = (((state == ACTIVE) & ~ioctl_download) | (state == DRAIN)) & (count_nx == 2'd0);
        to_drain   = (state == ACTIVE) & ~ioctl_download & (count_nx != 2'd0);
    end

    assign mem_wr     = (count != 2'd0);
    assign mem_addr   = ent0[EW-1:8];
    assign mem_data   = ent0[7:0];
    assign ioctl_wait = (count == 2'd2) | pending_start;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            dl_q          <= 1'b0;
            valid_r       <= 1'b0;
            pending_start <= 1'b0;
            idx_r         <= '0;
            pend_idx      <= '0;
            hold_cnt      <= '0;
            ent0          <= '0;
            ent1          <= '0;
            count         <= 2'd0;
            cpu_reset     <= 1'b0;
            load_done     <= 1'b0;
            load_len      <= '0;
            load_region   <= '0;
            load_err      <= 1'b0;
        end else begin
            dl_q      <= ioctl_download;
            load_done <= 1'b0;

            if (push & ~pop) begin
                if (count == 2'd0)
                    ent0 <= push_word;
                else
                    ent1 <= push_word;
            end else if (pop & ~push) begin
                ent0 <= ent1;
            end else if (push & pop) begin
                if (count == 2'd1) begin
                    ent0 <= push_word;
                end else begin
                    ent0 <= ent1;
                    ent1 <= push_word;
                end
            end
            count <= count_nx;

            if (push && (load_len != LEN_MAX))
                load_len <= load_len + 1'b1;
            if (wr_attempt & ~push)
                load_err <= 1'b1;

            // A new session requested while draining waits until load_done has shown.
            if (rise && (state == DRAIN)) begin
                pending_start <= 1'b1;
                pend_idx      <= ioctl_index;
            end

            if (start) begin
                state         <= ACTIVE;
                idx_r         <= start_idx;
                valid_r       <= ({1'b0, start_idx} < NUM_IDX);
                load_len      <= '0;
                load_err      <= 1'b0;
                cpu_reset     <= (start_idx == ROM_IDX);
                pending_start <= 1'b0;
            end else if (finish) begin
                load_done   <= 1'b1;
                load_region <= idx_r[RW-1:0];
                if (idx_r == ROM_IDX) begin
                    state    <= HOLD;
                    hold_cnt <= '0;
                end else begin
                    state <= IDLE;
                end
            end else if (to_drain) begin
                state <= DRAIN;
            end else if (state == HOLD) begin
                if (hold_cnt == HOLD_LAST) begin
                    cpu_reset <= 1'b0;
                    state     <= IDLE;
                end else begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_dl_region_loader.sv
// Bench for dl_region_loader: directed scenarios plus randomized sessions,
// checked against a queue-based model of the expected memory write stream.
module tb_dl_region_loader;
    localparam int NUM_REGIONS  = 4;
    localparam int IN_AW        = 14;
    localparam int OUT_AW       = 25;
    localparam int REGION_SHIFT = 16;
    localparam int ROM_INDEX    = 0;
    localparam int RESET_HOLD   = 16;
    localparam int RW           = 2;

    logic              clk_sys = 1'b0;
    logic              reset_n;
    logic              ioctl_download, ioctl_wr, mem_ack;
    logic [7:0]        ioctl_index, ioctl_dout;
    logic [IN_AW-1:0]  ioctl_addr;
    logic              ioctl_wait, mem_wr, cpu_reset, load_done, load_err;
    logic [OUT_AW-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic [IN_AW:0]    load_len;
    logic [RW-1:0]     load_region;

    dl_region_loader #(
        .NUM_REGIONS(NUM_REGIONS), .IN_AW(IN_AW), .OUT_AW(OUT_AW),
        .REGION_SHIFT(REGION_SHIFT), .ROM_INDEX(ROM_INDEX), .RESET_HOLD(RESET_HOLD)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_wr(mem_wr), .mem_ack(mem_ack), .cpu_reset(cpu_reset),
        .load_done(load_done), .load_len(load_len), .load_region(load_region),
        .load_err(load_err)
    );

    always #5 clk_sys = ~clk_sys;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: expected write stream as a bounded queue plus session bookkeeping.
    int mq_addr[$];
    int mq_data[$];
    int sess_seq = 0;
    int seen_seq = 0;
    int sess_idx = 0;
    int m_idx, m_len;
    bit m_valid, m_err;
    bit mon_en  = 1'b0;
    bit chk_wait = 1'b1;
    bit rnd_ack = 1'b0;

    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mq_addr.delete();
            mq_data.delete();
            m_len    = 0;
            m_err    = 1'b0;
            m_idx    = 0;
            m_valid  = 1'b0;
            seen_seq = sess_seq;
        end else begin
            bit pop, room;
            if (sess_seq != seen_seq) begin
                seen_seq = sess_seq;
                m_idx    = sess_idx;
                m_valid  = (sess_idx < NUM_REGIONS);
                m_len    = 0;
                m_err    = 1'b0;
            end
            pop  = (mq_addr.size() > 0) && mem_ack;
            room = (mq_addr.size() < 2) || pop;
            if (pop) begin
                void'(mq_addr.pop_front());
                void'(mq_data.pop_front());
            end
            if (ioctl_wr) begin
                if (m_valid && room) begin
                    mq_addr.push_back(m_idx * (1 << REGION_SHIFT) + int'(ioctl_addr));
                    mq_data.push_back(int'(ioctl_dout));
                    if (m_len < (1 << IN_AW))
                        m_len++;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    end

    always @(negedge clk_sys) begin
        if (reset_n && mon_en) begin
            check_eq("mem_wr", 32'(mem_wr), 32'(mq_addr.size() > 0));
            if (mq_addr.size() > 0) begin
                check_eq("mem_addr", 32'(mem_addr), mq_addr[0]);
                check_eq("mem_data", 32'(mem_data), mq_data[0]);
            end
            if (chk_wait)
                check_eq("ioctl_wait", 32'(ioctl_wait), 32'(mq_addr.size() == 2));
            if (load_done)
                check_eq("done_fifo_empty", 32'(mq_addr.size()), 32'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
        if (rnd_ack)
            mem_ack = 1'($urandom_range(0, 1));
    endtask

    task automatic start_sess(input int idx);
        ioctl_index    = 8'(idx);
        ioctl_download = 1'b1;
        sess_idx       = idx;
        sess_seq++;
        tick();
    endtask

    task automatic write_byte(input int a, input int d);
        ioctl_wr   = 1'b1;
        ioctl_addr = IN_AW'(a);
        ioctl_dout = 8'(d);
        tick();
        ioctl_wr   = 1'b0;
    endtask

    // Returns at the negedge where load_done is seen; lat counts negedges from the call.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_sys);
            if (load_done) begin
                lat = i;
                break;
            end
            if (rnd_ack)
                mem_ack = 1'($urandom_range(0, 1));
        end
        if (lat < 0) begin
            check_eq("load_done_timeout", 32'(load_done), 32'd1);
        end else begin
            check_eq("load_len", 32'(load_len), 32'(m_len));
            check_eq("load_err", 32'(load_err), 32'(m_err));
            if (m_valid)
                check_eq("load_region", 32'(load_region), 32'(m_idx));
        end
    endtask

    task automatic end_sess(output int lat);
        ioctl_download = 1'b0;
        wait_done(lat);
    endtask

    initial begin
        int lat;
        reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = '0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0; mem_ack = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        check_eq("rst_mem_wr", 32'(mem_wr), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_mem_data", 32'(mem_data), 32'd0);
        check_eq("rst_ioctl_wait", 32'(ioctl_wait), 32'd0);
        check_eq("rst_cpu_reset", 32'(cpu_reset), 32'd0);
        check_eq("rst_load_done", 32'(load_done), 32'd0);
        check_eq("rst_load_len", 32'(load_len), 32'd0);
        check_eq("rst_load_region", 32'(load_region), 32'd0);
        check_eq("rst_load_err", 32'(load_err), 32'd0);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        tick();

        // Index 1, two bytes, ack always high.
        mem_ack = 1'b1;
        start_sess(1);
        write_byte(0, 8'hAA);
        check_eq("t1_cpu_reset", 32'(cpu_reset), 32'd0);
        write_byte(1, 8'hBB);
        tick();
        end_sess(lat);
        check_eq("t1_done_latency", 32'(lat), 32'd1);
        check_eq("t1_len", 32'(load_len), 32'd2);
        check_eq("t1_region", 32'(load_region), 32'd1);
        @(negedge clk_sys);
        check_eq("t1_done_single", 32'(load_done), 32'd0);
        check_eq("t1_cpu_reset_end", 32'(cpu_reset), 32'd0);
        tick();

        // ROM index: cpu_reset window.
        ioctl_index = 8'(ROM_INDEX); ioctl_download = 1'b1; sess_idx = ROM_INDEX; sess_seq++;
        @(negedge clk_sys);
        check_eq("t2_cpu_reset_pre", 32'(cpu_reset), 32'd0);
        tick();
        @(negedge clk_sys);
        check_eq("t2_cpu_reset_rise", 32'(cpu_reset), 32'd1);
        tick();
        for (int i = 0; i < 3; i++) write_byte(i, 8'h10 + i);
        tick();
        end_sess(lat);
        check_eq("t2_len", 32'(load_len), 32'd3);
        check_eq("t2_cpu_reset_done", 32'(cpu_reset), 32'd1);
        for (int k = 1; k < RESET_HOLD; k++) begin
            @(negedge clk_sys);
            check_eq("t2_cpu_reset_hold", 32'(cpu_reset), 32'd1);
        end
        @(negedge clk_sys);
        check_eq("t2_cpu_reset_fall", 32'(cpu_reset), 32'd0);
        tick();

        // Stalled memory: third back-to-back byte is dropped.
        mem_ack = 1'b0;
        start_sess(2);
        write_byte(16'h100, 8'h01);
        write_byte(16'h101, 8'h02);
        write_byte(16'h102, 8'h03);
        check_eq("t3_err", 32'(load_err), 32'd1);
        check_eq("t3_wait", 32'(ioctl_wait), 32'd1);
        repeat (17) tick();
        mem_ack = 1'b1;
        tick();
        end_sess(lat);
        check_eq("t3_len", 32'(load_len), 32'd2);
        tick();

        // Out-of-range index, then a valid session clears the error.
        start_sess(5);
        write_byte(0, 8'h55);
        write_byte(1, 8'h66);
        end_sess(lat);
        check_eq("t4_err", 32'(load_err), 32'd1);
        check_eq("t4_len", 32'(load_len), 32'd0);
        tick();
        start_sess(3);
        @(negedge clk_sys);
        check_eq("t4_err_clear", 32'(load_err), 32'd0);
        tick();
        write_byte(16'h3FFF, 8'h77);
        tick();
        end_sess(lat);
        tick();

        // ROM load re-triggered 5 cycles into the reset hold.
        start_sess(ROM_INDEX);
        write_byte(7, 8'h99);
        tick();
        end_sess(lat);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_sys);
            check_eq("t5_cpu_reset_hold", 32'(cpu_reset), 32'd1);
        end
        tick();
        start_sess(ROM_INDEX);
        check_eq("t5_cpu_reset_restart", 32'(cpu_reset), 32'd1);
        for (int i = 0; i < 3; i++) begin
            write_byte(20 + i, 8'hC0 + i);
            check_eq("t5_cpu_reset_active", 32'(cpu_reset), 32'd1);
        end
        tick();
        end_sess(lat);
        check_eq("t5_len", 32'(load_len), 32'd3);
        repeat (RESET_HOLD + 4) tick();
        check_eq("t5_cpu_reset_off", 32'(cpu_reset), 32'd0);

        // Download rise while draining is deferred until after load_done.
        mem_ack = 1'b0;
        start_sess(1);
        write_byte(40, 8'h44);
        chk_wait = 1'b0;
        ioctl_download = 1'b0;
        tick(); tick();
        ioctl_index = 8'd2; ioctl_download = 1'b1;
        tick(); tick();
        check_eq("t6_wait_pending", 32'(ioctl_wait), 32'd1);
        mem_ack = 1'b1;
        wait_done(lat);
        check_eq("t6_len", 32'(load_len), 32'd1);
        check_eq("t6_wait_at_done", 32'(ioctl_wait), 32'd1);
        sess_idx = 2;
        sess_seq++;
        tick();
        chk_wait = 1'b1;
        check_eq("t6_wait_released", 32'(ioctl_wait), 32'd0);
        write_byte(41, 8'h45);
        tick();
        end_sess(lat);
        check_eq("t6_region", 32'(load_region), 32'd2);
        tick();

        // Asynchronous reset with two entries pending.
        mem_ack = 1'b0;
        start_sess(ROM_INDEX);
        write_byte(1, 8'hE1);
        write_byte(2, 8'hE2);
        check_eq("t7_wait_pre", 32'(ioctl_wait), 32'd1);
        check_eq("t7_cpu_reset_pre", 32'(cpu_reset), 32'd1);
        @(posedge clk_sys);
        #3;
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check_eq("t7_mem_wr", 32'(mem_wr), 32'd0);
        check_eq("t7_cpu_reset", 32'(cpu_reset), 32'd0);
        check_eq("t7_wait", 32'(ioctl_wait), 32'd0);
        check_eq("t7_len", 32'(load_len), 32'd0);
        ioctl_download = 1'b0;
        @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        mon_en  = 1'b1;
        mem_ack = 1'b1;
        tick();
        start_sess(1);
        write_byte(9, 8'h5A);
        tick();
        end_sess(lat);
        check_eq("t7_after_len", 32'(load_len), 32'd1);
        tick();

        // Randomized sessions with random memory back-pressure.
        rnd_ack = 1'b1;
        for (int s = 0; s < 30; s++) begin
            int idx, nb;
            idx = ($urandom_range(0, 9) == 0) ? 5 : int'($urandom_range(0, NUM_REGIONS - 1));
            nb  = int'($urandom_range(0, 8));
            start_sess(idx);
            for (int b = 0; b < nb; b++) begin
                repeat ($urandom_range(0, 2)) tick();
                if ($urandom_range(0, 3) != 0)
                    for (int w = 0; w < 100 && ioctl_wait; w++) tick();
                write_byte(int'($urandom_range(0, (1 << IN_AW) - 1)), int'($urandom_range(0, 255)));
            end
            end_sess(lat);
            tick();
        end
        rnd_ack = 1'b0;

        // Length saturation at 2^IN_AW.
        mem_ack = 1'b1;
        repeat (RESET_HOLD + 2) tick();
        start_sess(2);
        for (int b = 0; b <= (1 << IN_AW); b++)
            write_byte(b & ((1 << IN_AW) - 1), b & 8'hFF);
        tick();
        end_sess(lat);
        check_eq("t9_len_sat", 32'(load_len), 32'(1 << IN_AW));
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
